// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MC_BUSY = 1'b1
   } hz_state_t;

   localparam int REG_W_DEF = 5;
   localparam int MC_CNT_W  = 8;

endpackage

// File: rtl/mc_stall_counter.sv
// Down-counter timing the front-end freeze of a multi-cycle EX op.
module mc_stall_counter
   import hazard_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic [MC_CNT_W-1:0] load_val,
   input  logic                dec,
   output logic                zero
);

   logic [MC_CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use, branch-squash and multi-cycle EX stall control for the 5-stage pipeline.
// Define HAZ_PERF_CNT_EN to add the saturating stall_cycles counter output.
//
// state   | meaning
// RUN     | normal issue; resolves branch squash, MC entry and load-use bubbles
// MC_BUSY | front end frozen while a mult/div occupies EX; cnt==0 is the release cycle
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MUL_LAT = 4,
   parameter int REG_W   = REG_W_DEF
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             ex_multicycle,
   input  logic             ex_branch_taken,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             busy
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [31:0]      stall_cycles
`endif
);

   localparam bit                MC_EN   = (MUL_LAT > 1);
   localparam logic [MC_CNT_W-1:0] MC_LOAD = MC_CNT_W'(MUL_LAT - 2);

   hz_state_t state, state_nxt;
   logic      load_use;
   logic      cnt_load;
   logic      cnt_dec;
   logic      cnt_zero;

   assign load_use = ex_mem_read && (ex_rt != '0) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

   mc_stall_counter u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (MC_LOAD),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state <= RUN;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      id_ex_write = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      busy        = 1'b0;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
      if (reset) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_write = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         state_nxt   = RUN;
      end else begin
         case (state)
            RUN: begin
               if (ex_branch_taken) begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (ex_multicycle && MC_EN) begin
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  id_ex_write = 1'b0;
                  busy        = 1'b1;
                  cnt_load    = 1'b1;
                  state_nxt   = MC_BUSY;
               end else if (load_use) begin
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  id_ex_flush = 1'b1;
               end
            end
            MC_BUSY: begin
               busy = 1'b1;
               if (!cnt_zero) begin
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  id_ex_write = 1'b0;
                  cnt_dec     = 1'b1;
               end else begin
                  // Release: the held op must not re-enter, so only branch/load-use apply.
                  state_nxt = RUN;
                  if (ex_branch_taken) begin
                     if_id_flush = 1'b1;
                     id_ex_flush = 1'b1;
                  end else if (load_use) begin
                     pc_write    = 1'b0;
                     if_id_write = 1'b0;
                     id_ex_flush = 1'b1;
                  end
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

`ifdef HAZ_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset)
         stall_cycles <= '0;
      else if (!pc_write && stall_cycles != 32'hFFFF_FFFF)
         stall_cycles <= stall_cycles + 32'd1;
   end
`endif

endmodule
